periodometro_promediador: RTL

//   Parametrised successor of the square-wave period meter.
//   - Synchronises onda_cuadrada and detects its rising edges.
//   - Measures each period in ticks of DIV_TICK clocks, averages 2^LOG2_PROMEDIO periods
//     and converts the average to packed BCD with a sequential double-dabble.
//   - Adds saturation/overflow and no-signal timeout; outputs feed the existing

---
 rtl/periodometro_promediador.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/periodometro_promediador.sv
// Square-wave period meter: measures periods in prescaled ticks, averages 2^LOG2_PROMEDIO
// of them, converts the average to packed BCD and flags saturation and loss of signal.
module periodometro_promediador #(
    parameter int unsigned CANT_BITS     = 12,
    parameter int unsigned CANT_CIFRAS   = 4,
    parameter int unsigned DIV_TICK      = 50,
    parameter int unsigned LOG2_PROMEDIO = 2,
    parameter int unsigned TIMEOUT_TICKS = 8192
) (
    input  logic                       reloj_FPGA,
    input  logic                       reset,
    input  logic                       onda_cuadrada,
    output logic [CANT_BITS-1:0]       valor_periodo,
    output logic [4*CANT_CIFRAS-1:0]   reg_BCD,
    output logic                       dato_valido,
    output logic                       desborde,
    output logic                       sin_senial
);

    localparam int unsigned W_BCD        = 4 * CANT_CIFRAS;
    localparam int unsigned W_PRE        = (DIV_TICK > 1) ? $clog2(DIV_TICK) : 1;
    localparam int unsigned W_ACUM       = CANT_BITS + LOG2_PROMEDIO;
    localparam int unsigned W_N          = LOG2_PROMEDIO + 1;
    localparam int unsigned W_TO         = $clog2(TIMEOUT_TICKS + 1);
    localparam int unsigned W_PASO       = (CANT_BITS > 1) ? $clog2(CANT_BITS) : 1;
    localparam int unsigned N_PROM       = 2 ** LOG2_PROMEDIO;
    // The flanco clock is the first clock of the new period.
    localparam int unsigned PRESC_FLANCO = (DIV_TICK > 1) ? 1 : 0;
    localparam int unsigned CNT_FLANCO   = (DIV_TICK > 1) ? 0 : 1;
    localparam logic [CANT_BITS-1:0] CNT_MAX = '1;

    typedef enum logic {
        ESPERA   = 1'b0,
        MIDIENDO = 1'b1
    } estado_t;

    estado_t              r_estado;
    estado_t              w_estado_sig;

    logic                 r_sinc1;
    logic                 r_sinc2;
    logic                 r_prev;
    logic                 w_flanco;

    logic [W_PRE-1:0]     r_presc;
    logic                 w_tick;

    logic [CANT_BITS-1:0] r_cnt;
    logic                 r_sat;

    logic [W_TO-1:0]      r_to;
    logic                 w_timeout;

    logic [W_ACUM-1:0]    r_acum;
    logic [W_ACUM-1:0]    w_suma;
    logic [W_N-1:0]       r_n;
    logic                 r_sat_acum;
    logic                 w_acumular;
    logic                 w_cierre;
    logic                 w_captura;

    logic [CANT_BITS-1:0] r_resultado;
    logic                 r_sat_res;
    logic                 r_inicio;
    logic                 r_busy;
    logic                 r_fin;
    logic [CANT_BITS-1:0] r_bin;
    logic [W_BCD-1:0]     r_bcd;
    logic [W_BCD-1:0]     w_bcd_aj;
    logic [W_BCD-1:0]     w_bcd_sig;
    logic [W_PASO-1:0]    r_paso;

    // Two-flop synchroniser plus previous value for rising-edge detection.
    always_ff @(posedge reloj_FPGA) begin
        if (reset) begin
            r_sinc1 <= 1'b0;
            r_sinc2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sinc1 <= onda_cuadrada;
            r_sinc2 <= r_sinc1;
            r_prev  <= r_sinc2;
        end
    end

    assign w_flanco = r_sinc2 & ~r_prev;

    // Tick prescaler, re-phased on every edge.
    assign w_tick = (r_presc == W_PRE'(DIV_TICK - 1));

    always_ff @(posedge reloj_FPGA) begin
        if (reset) begin
            r_presc <= '0;
        end else if (w_flanco) begin
            r_presc <= W_PRE'(PRESC_FLANCO);
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Saturating period counter; a tick coinciding with flanco belongs to neither period.
    always_ff @(posedge reloj_FPGA) begin
        if (reset) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (w_flanco) begin
            r_cnt <= CANT_BITS'(CNT_FLANCO);
            r_sat <= 1'b0;
        end else if (w_tick) begin
            if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_cnt >= CNT_MAX - 1'b1) begin
                r_sat <= 1'b1;
            end
        end
    end

    // No-signal timeout; holds at TIMEOUT_TICKS so it fires only once per silence.
    assign w_timeout = w_tick & ~w_flanco & (r_to == W_TO'(TIMEOUT_TICKS - 1));

    always_ff @(posedge reloj_FPGA) begin
        if (reset || w_flanco) begin
            r_to <= '0;
        end else if (w_tick && (r_to != W_TO'(TIMEOUT_TICKS))) begin
            r_to <= r_to + 1'b1;
        end
    end

    always_ff @(posedge reloj_FPGA) begin
        if (reset) begin
            r_estado <= ESPERA;
        end else begin
            r_estado <= w_estado_sig;
        end
    end

    always_comb begin
        w_estado_sig = r_estado;
        w_acumular   = 1'b0;
        w_cierre     = 1'b0;
        case (r_estado)
            ESPERA: begin
                if (w_flanco) begin
                    w_estado_sig = MIDIENDO;
                end
            end
            MIDIENDO: begin
                if (w_timeout) begin
                    w_estado_sig = ESPERA;
                end else if (w_flanco) begin
                    w_acumular = 1'b1;
                    w_cierre   = (r_n == W_N'(N_PROM - 1));
                end
            end
            default: w_estado_sig = ESPERA;
        endcase
    end

    assign w_suma    = r_acum + W_ACUM'(r_cnt);
    assign w_captura = w_cierre & ~r_busy & ~r_inicio;

    // Running sum of the current set of periods.
    always_ff @(posedge reloj_FPGA) begin
        if (reset || w_timeout) begin
            r_acum     <= '0;
            r_n        <= '0;
            r_sat_acum <= 1'b0;
        end else if (w_acumular) begin
            if (w_cierre) begin
                r_acum     <= '0;
                r_n        <= '0;
                r_sat_acum <= 1'b0;
            end else begin
                r_acum     <= w_suma;
                r_n        <= r_n + 1'b1;
                r_sat_acum <= r_sat_acum | r_sat;
            end
        end
    end

    // Add-3 correction on every BCD digit before each shift.
    always_comb begin
        w_bcd_aj = r_bcd;
        for (int unsigned i = 0; i < CANT_CIFRAS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_aj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
        w_bcd_sig = {w_bcd_aj[W_BCD-2:0], r_bin[CANT_BITS-1]};
    end

    // Sequential double-dabble: load one cycle after capture, then CANT_BITS shifts.
    always_ff @(posedge reloj_FPGA) begin
        if (reset || w_timeout) begin
            r_resultado <= '0;
            r_sat_res   <= 1'b0;
            r_inicio    <= 1'b0;
            r_busy      <= 1'b0;
            r_fin       <= 1'b0;
            r_bin       <= '0;
            r_bcd       <= '0;
            r_paso      <= '0;
        end else begin
            r_fin    <= 1'b0;
            r_inicio <= w_captura;
            if (w_captura) begin
                r_resultado <= CANT_BITS'(w_suma >> LOG2_PROMEDIO);
                r_sat_res   <= r_sat_acum | r_sat;
            end
            if (r_inicio) begin
                r_bin  <= r_resultado;
                r_bcd  <= '0;
                r_paso <= '0;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_bin  <= r_bin << 1;
                r_bcd  <= w_bcd_sig;
                r_paso <= r_paso + 1'b1;
                if (r_paso == W_PASO'(CANT_BITS - 1)) begin
                    r_busy <= 1'b0;
                    r_fin  <= 1'b1;
                end
            end
        end
    end

    // Output registers: updated together on completion, zeroed on timeout.
    always_ff @(posedge reloj_FPGA) begin
        if (reset) begin
            valor_periodo <= '0;
            reg_BCD       <= '0;
            desborde      <= 1'b0;
            dato_valido   <= 1'b0;
            sin_senial    <= 1'b0;
        end else if (w_timeout) begin
            valor_periodo <= '0;
            reg_BCD       <= '0;
            desborde      <= 1'b0;
            dato_valido   <= 1'b0;
            sin_senial    <= 1'b1;
        end else begin
            dato_valido <= r_fin;
            if (r_fin) begin
                valor_periodo <= r_resultado;
                reg_BCD       <= r_bcd;
                desborde      <= r_sat_res;
                sin_senial    <= 1'b0;
            end
        end
    end

endmodule
